// File: rtl/dcsk_correlator.sv
// DCSK integrate-and-dump correlator.
// Sums SF consecutive valid reference*data products into one correlation
// value and makes the hard bit decision from the sign of the completed sum.
module dcsk_correlator #(
  parameter int WORD_LEN = 8,
  parameter int SF       = 16,
  parameter int ACC_LEN  = 2*WORD_LEN + $clog2(SF) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic signed [2*WORD_LEN-1:0] i_product,
  input  logic                       i_clear,
  output logic signed [ACC_LEN-1:0]  o_acc,
  output logic                       o_bit,
  output logic                       o_valid,
  output logic                       o_busy
);

  localparam int PROD_LEN = 2*WORD_LEN;
  localparam int CNT_W    = $clog2(SF);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SF - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                     state;
  logic signed [ACC_LEN-1:0]  acc;
  logic        [CNT_W-1:0]    cnt;
  logic signed [ACC_LEN-1:0]  prod_ext;
  logic signed [ACC_LEN-1:0]  sum;

  // Sign-extend the product to the accumulator width and form the running sum.
  assign prod_ext = {{(ACC_LEN-PROD_LEN){i_product[PROD_LEN-1]}}, i_product};
  assign sum      = acc + prod_ext;

  // Busy reflects the registered state, so it drops the cycle after a dump or clear.
  assign o_busy = (state == ACCUM);

  // Symbol state machine: accumulate, dump on the SF-th product, abort on clear.
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values of acc/cnt/state, exactly as the hardware flops do.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      o_acc   <= '0;
      o_bit   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        // Abort drops the partial symbol and this cycle's product; outputs hold.
        acc   <= '0;
        cnt   <= '0;
        state <= IDLE;
      end else if (i_valid) begin
        case (state)
          IDLE: begin
            acc   <= prod_ext;
            cnt   <= CNT_W'(1);
            state <= ACCUM;
          end
          ACCUM: begin
            if (cnt == LAST_CNT) begin
              o_acc   <= sum;
              o_bit   <= ~sum[ACC_LEN-1];
              o_valid <= 1'b1;
              acc     <= '0;
              cnt     <= '0;
              state   <= IDLE;
            end else begin
              acc <= sum;
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcsk_correlator.sv
// Scoreboard bench for dcsk_correlator with SF=4: the stimulus pushes expected
// dumps into a queue and a monitor pops and compares on every o_valid pulse.
module tb_dcsk_correlator;

  localparam int WORD_LEN = 8;
  localparam int SF       = 4;
  localparam int ACC_LEN  = 2*WORD_LEN + $clog2(SF) + 1;

  logic                         i_clk;
  logic                         i_rst;
  logic                         i_valid;
  logic signed [2*WORD_LEN-1:0] i_product;
  logic                         i_clear;
  logic signed [ACC_LEN-1:0]    o_acc;
  logic                         o_bit;
  logic                         o_valid;
  logic                         o_busy;

  typedef struct {
    int   acc;
    logic dec;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pushed   = 0;

  dcsk_correlator #(
    .WORD_LEN(WORD_LEN),
    .SF      (SF),
    .ACC_LEN (ACC_LEN)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_product(i_product),
    .i_clear  (i_clear),
    .o_acc    (o_acc),
    .o_bit    (o_bit),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input logic v, input int p, input logic c);
    @(posedge i_clk);
    #1;
    i_valid   = v;
    i_product = 16'(p);
    i_clear   = c;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic expect_dump(input int acc, input logic dec);
    exp_t e;
    e.acc = acc;
    e.dec = dec;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Monitor: every o_valid pulse must match the oldest pending expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dump: got o_acc=%0d o_bit=%0d, expected no pulse (t=%0t)",
                 o_acc, o_bit, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dump_acc", longint'(o_acc), longint'(e.acc));
        check("dump_bit", longint'(o_bit), longint'(e.dec));
      end
    end
  end

  initial begin
    int n;
    i_rst     = 1'b0;
    i_valid   = 1'b0;
    i_product = '0;
    i_clear   = 1'b0;

    // Test 1: asynchronous reset mid-cycle, before any clock edge.
    #2 i_rst = 1'b1;
    #1;
    check("rst_acc", longint'(o_acc), 0);
    check("rst_bit", longint'(o_bit), 0);
    check("rst_valid", longint'(o_valid), 0);
    check("rst_busy", longint'(o_busy), 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;
    idle(3);
    check("idle_acc", longint'(o_acc), 0);
    check("idle_busy", longint'(o_busy), 0);
    check("idle_valid", longint'(o_valid), 0);

    // Test 2: basic symbol, busy through samples 2-4, one-cycle pulse.
    expect_dump(115, 1'b1);
    drive(1'b1, 100, 1'b0);
    drive(1'b1, -20, 1'b0);
    check("busy_s2", longint'(o_busy), 1);
    drive(1'b1, 30, 1'b0);
    check("busy_s3", longint'(o_busy), 1);
    drive(1'b1, 5, 1'b0);
    check("busy_s4", longint'(o_busy), 1);
    drive(1'b0, 0, 1'b0);
    check("pulse_on", longint'(o_valid), 1);
    check("busy_after_dump", longint'(o_busy), 0);
    drive(1'b0, 0, 1'b0);
    check("pulse_off", longint'(o_valid), 0);
    check("acc_hold", longint'(o_acc), 115);
    idle(2);

    // Test 3: extreme magnitudes, no wrap.
    expect_dump(65536, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, 16384, 1'b0);
    idle(2);
    expect_dump(-65024, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, -16256, 1'b0);
    idle(2);

    // Test 4: bubbles of 0, 2 and 5 cycles between products.
    expect_dump(-4, 1'b0);
    n = pulse_cyc.size();
    drive(1'b1, -3, 1'b0);
    drive(1'b1, 2, 1'b0);
    idle(2);
    drive(1'b1, -4, 1'b0);
    idle(5);
    check("bubble_busy", longint'(o_busy), 1);
    check("bubble_no_pulse", longint'(pulse_cyc.size()), longint'(n));
    drive(1'b1, 1, 1'b0);
    idle(2);

    // Test 5: zero sum then a back-to-back symbol with no dead cycle.
    expect_dump(0, 1'b1);
    expect_dump(4, 1'b1);
    n = pulse_cyc.size();
    drive(1'b1, 7, 1'b0);
    drive(1'b1, -7, 1'b0);
    drive(1'b1, 3, 1'b0);
    drive(1'b1, -3, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, 1, 1'b0);
    idle(2);
    check("b2b_pulses", longint'(pulse_cyc.size() - n), 2);
    if (pulse_cyc.size() - n == 2)
      check("b2b_spacing", longint'(pulse_cyc[n+1] - pulse_cyc[n]), 4);

    // Test 6a: clear drops partial symbol and its own product; outputs hold.
    expect_dump(10, 1'b1);
    drive(1'b1, 50, 1'b0);
    drive(1'b1, 50, 1'b0);
    drive(1'b1, 99, 1'b1);
    drive(1'b1, 1, 1'b0);
    check("clear_busy", longint'(o_busy), 0);
    check("clear_acc_hold", longint'(o_acc), 4);
    drive(1'b1, 2, 1'b0);
    drive(1'b1, 3, 1'b0);
    drive(1'b1, 4, 1'b0);
    idle(2);

    // Test 6b: reset after three samples discards them; next symbol is clean.
    n = pulse_cyc.size();
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    i_valid = 1'b0;
    #1;
    check("midrst_acc", longint'(o_acc), 0);
    check("midrst_busy", longint'(o_busy), 0);
    @(negedge i_clk) i_rst = 1'b0;
    idle(2);
    check("midrst_no_pulse", longint'(pulse_cyc.size()), longint'(n));
    expect_dump(-2, 1'b0);
    drive(1'b1, 1, 1'b0);
    drive(1'b1, -2, 1'b0);
    drive(1'b1, 3, 1'b0);
    drive(1'b1, -4, 1'b0);
    idle(4);

    // Every expected dump must have been seen.
    check("pending_dumps", longint'(exp_q.size()), 0);
    check("pulse_total", longint'(pulse_cyc.size()), longint'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcsk_correlator.md
Name: dcsk_correlator

Overview:
- Integrate-and-dump correlator directly downstream of the Booth multiplier in the DCSK receiver.
- Each product is reference-chip × data-chip. The block accumulates SF consecutive valid products into one correlation value.
- On the SF-th sample it dumps the sum and makes the hard bit decision from its sign.
- Results feed the bit deframer.

Parameters:
- WORD_LEN, 8, width of the multiplier operands. Products are 2*WORD_LEN bits signed.
- SF, 16, spreading factor: products per symbol. Legal range is SF >= 2.
- ACC_LEN, 2*WORD_LEN+$clog2(SF)+1, accumulator/output width. This width guarantees no overflow for any SF-product sum.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  i_product is valid this cycle.
- i_product  in  2*WORD_LEN  signed product from the multiplier.
- i_clear  in  1  synchronous abort of the current symbol.
- o_acc  out  ACC_LEN  signed correlation sum of the last completed symbol.
- o_bit  out  1  hard decision of the last completed symbol.
- o_valid  out  1  one-cycle pulse: o_acc/o_bit updated.
- o_busy  out  1  high while a symbol is partially accumulated (state ACCUM).

Behaviour:
- Reset (i_rst high, asynchronous, any cycle):
  - state=IDLE, acc=0, cnt=0.
  - o_acc=0, o_bit=0, o_valid=0, o_busy=0.
  - Any partial symbol is discarded.
- State machine: IDLE, ACCUM. cnt is $clog2(SF) bits.
- IDLE:
  - i_valid=1: acc <= sign-extended i_product, cnt <= 1, go to ACCUM.
  - Otherwise hold.
- ACCUM, i_valid=0: hold acc, cnt and state. Bubbles of any length are allowed.
- ACCUM, i_valid=1 and cnt<SF-1: acc <= acc+sext(i_product), cnt <= cnt+1.
- ACCUM, i_valid=1 and cnt==SF-1 (final sample):
  - sum = acc+sext(i_product).
  - o_acc <= sum, o_bit <= ~sum[ACC_LEN-1] (sum >= 0 gives 1, sum < 0 gives 0; zero gives 1).
  - o_valid <= 1 for exactly one cycle.
  - acc <= 0, cnt <= 0, go to IDLE.
- Latency: o_valid is high in the cycle after the SF-th accepted product is sampled.
- Back-to-back symbols: a valid product in the cycle immediately after the final sample is accepted by IDLE as sample 1 of the next symbol. There is no dead cycle, giving full throughput of one product per clock.
- i_clear (synchronous):
  - Priority over i_valid.
  - acc <= 0, cnt <= 0, state <= IDLE.
  - The product presented in that cycle is dropped.
  - No o_valid; o_acc/o_bit keep their previous values.
- o_acc/o_bit hold between dumps. o_valid is the only pulse output.
- o_busy = (state==ACCUM). It is registered, so it is low in the cycle after the final sample or a clear.
- Arithmetic: two's complement throughout. Each product is sign-extended to ACC_LEN before adding. No saturation is needed or implemented.

Test Plan (WORD_LEN=8, SF=4, ACC_LEN=19):
1. Assert i_rst asynchronously mid-cycle -> all outputs 0 immediately. After release with no valid input, outputs stay 0.
2. Products 100, -20, 30, 5 on 4 consecutive cycles -> next cycle o_valid=1 for one cycle, o_acc=115, o_bit=1, o_busy=1 during cycles 2-4.
3. Extreme magnitudes:
   - Four products of 16384 (-128×-128) -> o_acc=65536, o_bit=1.
   - Four products of -16256 -> o_acc=-65024, o_bit=0. No wrap in either case.
4. Products -3, 2, -4, 1 with i_valid low for 0, 2 and 5 cycles between them -> o_valid only after the 4th valid product; o_acc=-4, o_bit=0.
5. Zero sum and back-to-back symbols:
   - Products 7, -7, 3, -3 immediately followed by 1, 1, 1, 1 -> o_acc=0, o_bit=1.
   - Four cycles after that first dump: o_acc=4, o_bit=1.
   - Two o_valid pulses, 4 cycles apart.
6. Abort paths:
   - Two products (50, 50), then i_clear with i_valid=1 and product 99, then 1, 2, 3, 4 -> single dump o_acc=10.
   - Separately, assert i_rst after 3 samples -> no o_valid; the next 4 products form a clean symbol.
